if_fetch: RTL and testbench

Instruction fetch unit for the RV32I pipeline; it produces the `pc`/`inst` pair consumed by the decode stage.
- Reads one 32-bit instruction as four little-endian bytes over the shared 8-bit synchronous memory port.
- Holds the assembled instruction until decode accepts it.
- Yields the memory port to the load/store stage when that stage needs it.
- Redirects on taken branches and jumps signalled from execute.

---
 rtl/if_fetch.sv | 177 +++++++++++++++++
 tb/tb_if_fetch.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch.sv
// Instruction fetch: assembles a 32-bit instruction from four byte reads and holds it for decode.
// Optional direct-mapped icache enabled by defining ICACHE_EN.
module if_fetch #(
  parameter logic [31:0] RESET_PC     = 32'h0,
  parameter int unsigned ICACHE_IDX_W = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_busy_i,
  output logic [31:0] mem_a_o,
  output logic        mem_rd_o,
  input  logic [7:0]  mem_din_i,
  input  logic        jump_i,
  input  logic [31:0] jump_addr_i,
  input  logic        id_ready_i,
  output logic        inst_valid_o,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o
);

  typedef enum logic [0:0] {StFetch, StHold} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [2:0]  issue_idx_q, issue_idx_d;
  logic [1:0]  recv_idx_q, recv_idx_d;
  logic        pend_q, pend_d;
  logic [7:0]  b0_q, b0_d, b1_q, b1_d, b2_q, b2_d;
  logic [31:0] inst_q, inst_d;
  logic        valid_q, valid_d;

  logic        issue;
  logic        fill_done;
  logic        hit;
  logic [31:0] hit_inst;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    issue_idx_d = issue_idx_q;
    recv_idx_d  = recv_idx_q;
    pend_d      = pend_q;
    b0_d        = b0_q;
    b1_d        = b1_q;
    b2_d        = b2_q;
    inst_d      = inst_q;
    valid_d     = valid_q;
    issue       = 1'b0;
    fill_done   = 1'b0;

    if (jump_i) begin
      // Redirect wins over everything, including a same-cycle decode accept.
      pc_d        = jump_addr_i;
      state_d     = StFetch;
      issue_idx_d = 3'd0;
      recv_idx_d  = 2'd0;
      pend_d      = 1'b0;
      valid_d     = 1'b0;
    end else begin
      unique case (state_q)
        StFetch: begin
          if (hit) begin
            inst_d  = hit_inst;
            valid_d = 1'b1;
            state_d = StHold;
            pend_d  = 1'b0;
          end else begin
            if (pend_q) begin
              unique case (recv_idx_q)
                2'd0: b0_d = mem_din_i;
                2'd1: b1_d = mem_din_i;
                2'd2: b2_d = mem_din_i;
                2'd3: begin
                  inst_d    = {mem_din_i, b2_q, b1_q, b0_q};
                  valid_d   = 1'b1;
                  state_d   = StHold;
                  fill_done = 1'b1;
                end
              endcase
              recv_idx_d = recv_idx_q + 2'd1;
            end
            if (!mem_busy_i && issue_idx_q < 3'd4) begin
              issue       = 1'b1;
              pend_d      = 1'b1;
              issue_idx_d = issue_idx_q + 3'd1;
            end else begin
              pend_d = 1'b0;
            end
          end
        end
        StHold: begin
          if (id_ready_i) begin
            pc_d        = pc_q + 32'd4;
            valid_d     = 1'b0;
            issue_idx_d = 3'd0;
            recv_idx_d  = 2'd0;
            pend_d      = 1'b0;
            state_d     = StFetch;
          end
        end
        default: state_d = StFetch;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StFetch;
      pc_q        <= RESET_PC;
      issue_idx_q <= 3'd0;
      recv_idx_q  <= 2'd0;
      pend_q      <= 1'b0;
      b0_q        <= 8'd0;
      b1_q        <= 8'd0;
      b2_q        <= 8'd0;
      inst_q      <= 32'd0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      issue_idx_q <= issue_idx_d;
      recv_idx_q  <= recv_idx_d;
      pend_q      <= pend_d;
      b0_q        <= b0_d;
      b1_q        <= b1_d;
      b2_q        <= b2_d;
      inst_q      <= inst_d;
      valid_q     <= valid_d;
    end
  end

`ifdef ICACHE_EN
  localparam int unsigned Entries = 2 ** ICACHE_IDX_W;
  localparam int unsigned TagW    = 30 - ICACHE_IDX_W;

  logic [Entries-1:0]      cache_valid_q;
  logic [TagW-1:0]         cache_tag_q  [Entries];
  logic [31:0]             cache_data_q [Entries];
  logic [ICACHE_IDX_W-1:0] cache_idx;
  logic [TagW-1:0]         cache_tag;

  assign cache_idx = pc_q[ICACHE_IDX_W+1:2];
  assign cache_tag = pc_q[31:ICACHE_IDX_W+2];
  // Lookup only before the first byte of this PC has gone out.
  assign hit       = (state_q == StFetch) && (issue_idx_q == 3'd0) && !pend_q &&
                     cache_valid_q[cache_idx] && (cache_tag_q[cache_idx] == cache_tag);
  assign hit_inst  = cache_data_q[cache_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      cache_valid_q <= '0;
    end else if (fill_done) begin
      cache_valid_q[cache_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_done) begin
      cache_tag_q[cache_idx]  <= cache_tag;
      cache_data_q[cache_idx] <= inst_d;
    end
  end
`else
  logic [32:0] unused_cfg;

  assign hit        = 1'b0;
  assign hit_inst   = 32'd0;
  assign unused_cfg = {fill_done, 32'(ICACHE_IDX_W)};
`endif

  assign mem_rd_o     = issue & ~rst;
  assign mem_a_o      = mem_rd_o ? (pc_q + {29'd0, issue_idx_q}) : 32'd0;
  assign inst_valid_o = valid_q;
  assign pc_o         = pc_q;
  assign inst_o       = inst_q;

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: byte-memory model, PC/instruction scoreboard checked every cycle,
// plus directed timing checks with hand-computed values.
module tb_if_fetch;

  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk = 1'b0;
  logic        rst;
  logic        busy;
  logic [31:0] a;
  logic        rd;
  logic [7:0]  din = 8'hee;
  logic        jump;
  logic [31:0] jaddr;
  logic        ready;
  logic        valid;
  logic [31:0] pc;
  logic [31:0] inst;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  mem [1024];
  logic [31:0] exp_pc;
  int          k;

  if_fetch #(
    .RESET_PC    (RESET_PC),
    .ICACHE_IDX_W(6)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .mem_busy_i  (busy),
    .mem_a_o     (a),
    .mem_rd_o    (rd),
    .mem_din_i   (din),
    .jump_i      (jump),
    .jump_addr_i (jaddr),
    .id_ready_i  (ready),
    .inst_valid_o(valid),
    .pc_o        (pc),
    .inst_o      (inst)
  );

  always #5 clk = ~clk;

  // Synchronous byte memory: data appears the cycle after the address.
  always @(posedge clk) begin
    if (rd) din <= mem[a[9:0]];
    else    din <= 8'hee;
  end

  function automatic logic [31:0] word(input logic [31:0] addr);
    return {mem[addr[9:0] + 10'd3], mem[addr[9:0] + 10'd2], mem[addr[9:0] + 10'd1],
            mem[addr[9:0]]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int budget, input string name);
    int n = 0;
    while (valid !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, valid, 1);
  endtask

  // Scoreboard: expected PC follows transfers and redirects; k counts bytes issued for it.
  always @(negedge clk) begin
    logic exp_rd;
    if (rst) begin
      chk("rd_in_rst", rd, 0);
      chk("addr_in_rst", a, 0);
      exp_pc = RESET_PC;
      k      = 0;
    end else begin
      exp_rd = !jump && !busy && !valid && (k < 4);
`ifdef ICACHE_EN
      if (rd) chk("rd_allowed", exp_rd, 1);
`else
      chk("rd_rule", rd, exp_rd);
`endif
      if (rd) chk("fetch_addr", a, exp_pc + k);
      else    chk("addr_idle", a, 0);
      if (valid) begin
        chk("pc", pc, exp_pc);
        chk("inst", inst, word(exp_pc));
      end
      if (jump) begin
        exp_pc = jaddr;
        k      = 0;
      end else if (valid && ready) begin
        exp_pc = exp_pc + 32'd4;
        k      = 0;
      end else if (rd) begin
        k++;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'(i * 7 + 3);
    mem[0] = 8'h93; mem[1] = 8'h00; mem[2] = 8'h50; mem[3] = 8'h00;
    rst = 1'b1; busy = 1'b0; jump = 1'b0; jaddr = 32'h0; ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_valid", valid, 0);
    chk("rst_pc", pc, RESET_PC);
    chk("rst_inst", inst, 0);
    chk("model_word0", word(32'h0), 32'h00500093);

    // Unstalled fetch from reset, decode always ready.
    tick(); rst = 1'b0; ready = 1'b1;
    for (int c = 0; c < 7; c++) begin
      if (c > 0) tick();
      if (c == 6) ready = 1'b0;
      @(negedge clk);
      if (c < 4) begin
        chk("t1_rd", rd, 1);
        chk("t1_addr", a, c);
      end
      if (c == 4) chk("t1_idle_rd", rd, 0);
      if (c == 4) chk("t1_not_yet_valid", valid, 0);
      if (c == 5) begin
        chk("t1_valid", valid, 1);
        chk("t1_pc", pc, 32'h0);
        chk("t1_inst", inst, 32'h00500093);
      end
      if (c == 6) chk("t1_next_addr", a, 32'h4);
    end

    // Decode stalls: instruction at 4 held for ten cycles, then accepted.
    for (int c = 7; c <= 21; c++) begin
      tick();
      if (c == 21) ready = 1'b1;
      @(negedge clk);
      if (c >= 11) begin
        chk("t2_valid", valid, 1);
        chk("t2_rd", rd, 0);
        chk("t2_pc", pc, 32'h4);
        chk("t2_inst", inst, word(32'h4));
      end
    end

    // Memory port busy for cycles 2..4 of the fetch at 8.
    for (int c = 0; c <= 8; c++) begin
      tick();
      ready = 1'b0;
      busy  = (c >= 2 && c <= 4);
      @(negedge clk);
      if (c == 0) chk("t3_addr0", a, 32'h8);
      if (c == 1) chk("t3_addr1", a, 32'h9);
      if (c == 2) chk("t3_busy_rd", rd, 0);
      if (c == 5) chk("t3_addr2", a, 32'ha);
      if (c == 7) chk("t3_not_yet_valid", valid, 0);
      if (c == 8) begin
        chk("t3_valid", valid, 1);
        chk("t3_pc", pc, 32'h8);
        chk("t3_inst", inst, word(32'h8));
      end
    end
    busy = 1'b0;

    // Accept 8, then redirect to 0x100 in cycle 3 of the fetch at 12.
    tick(); ready = 1'b1;
    @(negedge clk);
    chk("t4_accept_valid", valid, 1);
    for (int c = 0; c <= 11; c++) begin
      tick();
      ready = (c == 10);
      jump  = (c == 3) || (c == 10);
      jaddr = (c == 10) ? 32'h40 : 32'h100;
      @(negedge clk);
      if (c <= 8) chk("t4_no_valid", valid, 0);
      if (c == 3) chk("t4_jump_rd", rd, 0);
      if (c == 4) begin
        chk("t4_target_rd", rd, 1);
        chk("t4_target_addr", a, 32'h100);
      end
      if (c == 9) begin
        chk("t4_valid", valid, 1);
        chk("t4_pc", pc, 32'h100);
      end
      if (c == 10) chk("t5_still_valid", valid, 1);
      if (c == 11) begin
        chk("t5_valid_drop", valid, 0);
        chk("t5_target_addr", a, 32'h40);
      end
    end
    wait_valid(20, "t5_valid_timeout");
    chk("t5_pc", pc, 32'h40);

    // Mixed busy / ready pattern, scoreboard does the checking.
    for (int c = 0; c < 60; c++) begin
      tick();
      busy  = (c % 5 == 1);
      ready = (c % 3 != 0);
      @(negedge clk);
    end

    // Reset in the middle of a fetch.
    tick(); busy = 1'b0; ready = 1'b1;
    begin
      int n = 0;
      while (rd !== 1'b1 && n < 20) begin
        @(negedge clk);
        n++;
      end
    end
    chk("t6_sync_rd", rd, 1);
    tick(); rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_valid", valid, 0);
    tick(); rst = 1'b0; ready = 1'b0;
    @(negedge clk);
    chk("t6_restart_rd", rd, 1);
    chk("t6_restart_addr", a, RESET_PC);
    wait_valid(20, "t6_valid_timeout");
    chk("t6_pc", pc, RESET_PC);
    chk("t6_inst", inst, 32'h00500093);

`ifdef ICACHE_EN
    // Two-instruction loop: second pass hits, reset clears the cache.
    tick(); rst = 1'b1;
    tick(); rst = 1'b0; ready = 1'b1;
    for (int c = 0; c <= 18; c++) begin
      if (c > 0) tick();
      jump  = (c == 12);
      jaddr = 32'h0;
      rst   = (c == 17);
      @(negedge clk);
      if (c == 0) chk("c_miss0_rd", rd, 1);
      if (c == 6) chk("c_miss4_rd", rd, 1);
      if (c == 13) chk("c_hit0_rd", rd, 0);
      if (c == 14) begin
        chk("c_hit0_valid", valid, 1);
        chk("c_hit0_pc", pc, 32'h0);
      end
      if (c == 15) chk("c_hit4_rd", rd, 0);
      if (c == 16) begin
        chk("c_hit4_valid", valid, 1);
        chk("c_hit4_inst", inst, word(32'h4));
      end
      if (c == 18) chk("c_after_rst_rd", rd, 1);
    end
`endif

    tick(); ready = 1'b0;
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
